// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles every signal between the issue controller and its neighbours
// (instruction fetch, register file, ALU, write-back port, data memory, status).
//   master : the controller side (alu_issue_ctrl)
//   slave  : the environment side (fetch / regfile / ALU / memory)
interface alu_issue_if;
  // Instruction fetch handshake
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  // Register file read port
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  // ALU
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_func;
  logic [6:0]  alu_opcode;
  logic        alu_en;
  logic [31:0] alu_y;
  // Register write-back
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        rd_we;
  // Data memory
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // Status
  logic        done;
  logic        illegal;

  modport master (
    input  instr_valid, instr, rs1_data, rs2_data, alu_y, mem_ack, mem_rdata,
    output instr_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_func, alu_opcode, alu_en,
           rd_addr, rd_wdata, rd_we, mem_req, mem_we, mem_addr, mem_wdata, done, illegal
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data, alu_y, mem_ack, mem_rdata,
    input  instr_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_func, alu_opcode, alu_en,
           rd_addr, rd_wdata, rd_we, mem_req, mem_we, mem_addr, mem_wdata, done, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/control sequencer for a non-pipelined RV32I core.
// Accepts one instruction per handshake, decodes it into ALU opcode/func/operands, fires a
// one-cycle alu_en, captures the result and completes with a register write-back or a word
// memory access.
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_issue_if.master (fetch, regfile, ALU, write-back, memory, done/illegal)
module alu_issue_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_if.master   bus
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  // Load opcode as the ALU expects to see it
  localparam logic [6:0] AluOpLoad = 7'b0000001;

  localparam logic [2:0] FnAdd = 3'b000;
  localparam logic [2:0] FnSub = 3'b001;
  localparam logic [2:0] FnAnd = 3'b010;
  localparam logic [2:0] FnOr  = 3'b011;
  localparam logic [2:0] FnXor = 3'b100;
  localparam logic [2:0] FnSll = 3'b101;
  localparam logic [2:0] FnSrl = 3'b110;

  typedef enum logic [2:0] {
    StIdle, StDecode, StExec, StCapture, StMem, StWb
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_func_q, alu_func_d;
  logic [6:0]  alu_opcode_q, alu_opcode_d;
  logic [31:0] result_q, result_d;
  logic [31:0] store_data_q, store_data_d;

  // Fields of the latched instruction
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, shamt_i, shamt_r;
  logic        is_store, is_mem;

  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[31:25];
  assign imm_i    = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign shamt_i  = {27'b0, instr_q[24:20]};
  assign shamt_r  = {27'b0, bus.rs2_data[4:0]};
  assign is_store = (opcode == OpStore);
  assign is_mem   = is_store || (opcode == OpLoad);

  // Decode result, only consumed in StDecode
  logic        dec_legal;
  logic [31:0] dec_b;
  logic [2:0]  dec_func;
  logic [6:0]  dec_opcode;

  always_comb begin
    dec_legal  = 1'b0;
    dec_b      = 32'b0;
    dec_func   = FnAdd;
    dec_opcode = opcode;
    case (opcode)
      OpR: begin
        dec_b = bus.rs2_data;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1;
            end else if (funct7 == 7'b0100000) begin
              dec_legal = 1'b1;
              dec_func  = FnSub;
            end
          end
          3'b111: begin dec_legal = (funct7 == 7'b0); dec_func = FnAnd; end
          3'b110: begin dec_legal = (funct7 == 7'b0); dec_func = FnOr;  end
          3'b100: begin dec_legal = (funct7 == 7'b0); dec_func = FnXor; end
          3'b001: begin dec_legal = (funct7 == 7'b0); dec_func = FnSll; dec_b = shamt_r; end
          3'b101: begin dec_legal = (funct7 == 7'b0); dec_func = FnSrl; dec_b = shamt_r; end
          default: dec_legal = 1'b0;
        endcase
      end
      OpI: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_legal = 1'b1;
          3'b111: begin dec_legal = 1'b1; dec_func = FnAnd; end
          3'b110: begin dec_legal = 1'b1; dec_func = FnOr;  end
          3'b100: begin dec_legal = 1'b1; dec_func = FnXor; end
          3'b001: begin dec_legal = (funct7 == 7'b0); dec_func = FnSll; dec_b = shamt_i; end
          3'b101: begin dec_legal = (funct7 == 7'b0); dec_func = FnSrl; dec_b = shamt_i; end
          default: dec_legal = 1'b0;
        endcase
      end
      OpLoad: begin
        dec_legal  = (funct3 == 3'b010);
        dec_b      = imm_i;
        dec_opcode = AluOpLoad;
      end
      OpStore: begin
        dec_legal = (funct3 == 3'b010);
        dec_b     = imm_s;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_func_d   = alu_func_q;
    alu_opcode_d = alu_opcode_q;
    result_d     = result_q;
    store_data_d = store_data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Operands only move here, so they settle a full cycle before alu_en
        if (dec_legal) begin
          alu_a_d      = bus.rs1_data;
          alu_b_d      = dec_b;
          alu_func_d   = dec_func;
          alu_opcode_d = dec_opcode;
          store_data_d = bus.rs2_data;
          state_d      = StExec;
        end else begin
          state_d = StIdle;
        end
      end
      StExec: state_d = StCapture;
      StCapture: begin
        result_d = bus.alu_y;
        state_d  = is_mem ? StMem : StWb;
      end
      StMem: begin
        if (bus.mem_ack) begin
          if (is_store) begin
            state_d = StIdle;
          end else begin
            result_d = bus.mem_rdata;
            state_d  = StWb;
          end
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      instr_q      <= 32'b0;
      alu_a_q      <= 32'b0;
      alu_b_q      <= 32'b0;
      alu_func_q   <= 3'b0;
      alu_opcode_q <= 7'b0;
      result_q     <= 32'b0;
      store_data_q <= 32'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_func_q   <= alu_func_d;
      alu_opcode_q <= alu_opcode_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
    end
  end

  // Datapath outputs
  assign bus.rs1_addr   = instr_q[19:15];
  assign bus.rs2_addr   = instr_q[24:20];
  assign bus.rd_addr    = instr_q[11:7];
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_func   = alu_func_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.rd_wdata   = result_q;
  assign bus.mem_addr   = result_q;
  assign bus.mem_wdata  = store_data_q;

  // Control outputs decoded from state, so reset clears them immediately
  always_comb begin
    bus.instr_ready = (state_q == StIdle);
    bus.illegal     = (state_q == StDecode) && !dec_legal;
    bus.alu_en      = (state_q == StExec);
    bus.mem_req     = (state_q == StMem);
    bus.mem_we      = (state_q == StMem) && is_store;
    bus.done        = (state_q == StWb) || ((state_q == StMem) && is_store && bus.mem_ack);
    bus.rd_we       = (state_q == StWb) && (instr_q[11:7] != 5'd0);
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic clk;
  logic rst_n;

  alu_issue_if bus ();

  alu_issue_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model (x0 reads zero)
  logic [31:0] regs [32];
  assign bus.rs1_data = (bus.rs1_addr == 5'd0) ? 32'b0 : regs[bus.rs1_addr];
  assign bus.rs2_data = (bus.rs2_addr == 5'd0) ? 32'b0 : regs[bus.rs2_addr];

  // ALU model: evaluates on the rising edge of alu_en
  always @(posedge bus.alu_en) begin
    case (bus.alu_func)
      3'b000:  bus.alu_y <= bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_y <= bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_y <= bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_y <= bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_y <= bus.alu_a ^ bus.alu_b;
      3'b101:  bus.alu_y <= bus.alu_a << bus.alu_b[4:0];
      3'b110:  bus.alu_y <= bus.alu_a >> bus.alu_b[4:0];
      default: bus.alu_y <= 32'hxxxx_xxxx;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  vec_t v;

  initial begin
    vecs[0]  = '{32'h002081B3, 32'd5, 32'd7, 1'b0, 32'd5, 32'd7, 3'd0, 7'h33, 5'd3, 1'b1, 32'd12};
    vecs[1]  = '{32'h402081B3, 32'd3, 32'd5, 1'b0, 32'd3, 32'd5, 3'd1, 7'h33, 5'd3, 1'b1,
                 32'hFFFF_FFFE};
    vecs[2]  = '{32'h00209233, 32'd1, 32'd33, 1'b0, 32'd1, 32'd1, 3'd5, 7'h33, 5'd4, 1'b1, 32'd2};
    vecs[3]  = '{32'h0040D293, 32'h8000_0000, 32'd0, 1'b0, 32'h8000_0000, 32'd4, 3'd6, 7'h13,
                 5'd5, 1'b1, 32'h0800_0000};
    vecs[4]  = '{32'h00108013, 32'd9, 32'd0, 1'b0, 32'd9, 32'd1, 3'd0, 7'h13, 5'd0, 1'b0, 32'd10};
    vecs[5]  = '{32'h0020F3B3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F,
                 3'd2, 7'h33, 5'd7, 1'b1, 32'h00F0_000F};
    vecs[6]  = '{32'hFFF0E413, 32'h1234_5678, 32'd0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 3'd3,
                 7'h13, 5'd8, 1'b1, 32'hFFFF_FFFF};
    vecs[7]  = '{32'h0F00C493, 32'h0000_0FFF, 32'd0, 1'b0, 32'h0000_0FFF, 32'h0000_00F0, 3'd4,
                 7'h13, 5'd9, 1'b1, 32'h0000_0F0F};
    // SRA, BEQ, LB, SLT
    vecs[8]  = '{32'h4020D1B3, 32'd1, 32'd2, 1'b1, 32'd0, 32'd0, 3'd0, 7'h00, 5'd0, 1'b0, 32'd0};
    vecs[9]  = '{32'h00208063, 32'd1, 32'd2, 1'b1, 32'd0, 32'd0, 3'd0, 7'h00, 5'd0, 1'b0, 32'd0};
    vecs[10] = '{32'h00010203, 32'd1, 32'd2, 1'b1, 32'd0, 32'd0, 3'd0, 7'h00, 5'd0, 1'b0, 32'd0};
    vecs[11] = '{32'h0020A1B3, 32'd1, 32'd2, 1'b1, 32'd0, 32'd0, 3'd0, 7'h00, 5'd0, 1'b0, 32'd0};

    for (int i = 0; i < 32; i++) regs[i] = 32'b0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 32'b0;
    bus.alu_y       = 32'b0;
    #23;

    // Reset state
    check("rst instr_ready", bus.instr_ready, 1);
    check("rst alu_en", bus.alu_en, 0);
    check("rst alu_a", bus.alu_a, 0);
    check("rst rd_we", bus.rd_we, 0);
    check("rst mem_req", bus.mem_req, 0);
    check("rst done", bus.done, 0);
    check("rst illegal", bus.illegal, 0);
    rst_n = 1'b1;
    step();

    // Table-driven R/I and illegal vectors
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      regs[v.instr[24:20]] = v.r2;
      regs[v.instr[19:15]] = v.r1;
      check("c0 instr_ready", bus.instr_ready, 1);
      bus.instr       = v.instr;
      bus.instr_valid = 1'b1;
      step();  // cycle 1
      bus.instr_valid = 1'b0;
      check("c1 illegal", bus.illegal, v.ill);
      check("c1 alu_en", bus.alu_en, 0);
      check("c1 instr_ready", bus.instr_ready, 0);
      step();  // cycle 2
      if (v.ill) begin
        check("ill c2 instr_ready", bus.instr_ready, 1);
        check("ill c2 alu_en", bus.alu_en, 0);
        check("ill c2 illegal", bus.illegal, 0);
        check("ill c2 mem_req", bus.mem_req, 0);
        check("ill c2 rd_we", bus.rd_we, 0);
      end else begin
        check("c2 alu_en", bus.alu_en, 1);
        check("c2 alu_a", bus.alu_a, v.a);
        check("c2 alu_b", bus.alu_b, v.b);
        check("c2 alu_func", {29'b0, bus.alu_func}, {29'b0, v.func});
        check("c2 alu_opcode", {25'b0, bus.alu_opcode}, {25'b0, v.opc});
        step();  // cycle 3
        check("c3 alu_en", bus.alu_en, 0);
        check("c3 done", bus.done, 0);
        check("c3 alu_b held", bus.alu_b, v.b);
        step();  // cycle 4
        check("c4 done", bus.done, 1);
        check("c4 rd_we", bus.rd_we, v.we);
        check("c4 rd_addr", {27'b0, bus.rd_addr}, {27'b0, v.rd});
        check("c4 rd_wdata", bus.rd_wdata, v.wdata);
        check("c4 mem_req", bus.mem_req, 0);
        step();  // cycle 5
        check("c5 instr_ready", bus.instr_ready, 1);
        check("c5 done", bus.done, 0);
        check("c5 rd_we", bus.rd_we, 0);
      end
    end

    // LW x4,-4(x2): ack held low through cycles 4..6
    regs[2] = 32'h0000_0100;
    bus.instr = 32'hFFC12203;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    check("lw c1 illegal", bus.illegal, 0);
    step();
    check("lw c2 alu_en", bus.alu_en, 1);
    check("lw c2 alu_b", bus.alu_b, 32'hFFFF_FFFC);
    check("lw c2 alu_func", {29'b0, bus.alu_func}, 0);
    check("lw c2 alu_opcode", {25'b0, bus.alu_opcode}, 32'h01);
    step();
    step();  // cycle 4
    for (int c = 4; c <= 6; c++) begin
      check("lw mem_req", bus.mem_req, 1);
      check("lw mem_we", bus.mem_we, 0);
      check("lw mem_addr", bus.mem_addr, 32'h0000_00FC);
      check("lw done", bus.done, 0);
      check("lw rd_we", bus.rd_we, 0);
      step();
    end
    bus.mem_ack   = 1'b1;  // cycle 7
    bus.mem_rdata = 32'hDEAD_BEEF;
    check("lw c7 mem_req", bus.mem_req, 1);
    step();  // cycle 8
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'b0;
    check("lw wb mem_req", bus.mem_req, 0);
    check("lw wb rd_we", bus.rd_we, 1);
    check("lw wb rd_addr", {27'b0, bus.rd_addr}, 32'd4);
    check("lw wb rd_wdata", bus.rd_wdata, 32'hDEAD_BEEF);
    check("lw wb done", bus.done, 1);
    step();
    check("lw idle", bus.instr_ready, 1);

    // SW x6,8(x2): ack high before MEM (ignored) and still high on entry
    regs[6] = 32'hCAFE_F00D;
    bus.instr = 32'h00612423;
    bus.instr_valid = 1'b1;
    bus.mem_ack = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();  // cycle 2
    check("sw c2 alu_b", bus.alu_b, 32'd8);
    check("sw c2 alu_opcode", {25'b0, bus.alu_opcode}, 32'h23);
    step();
    check("sw c3 mem_req", bus.mem_req, 0);
    check("sw c3 done", bus.done, 0);
    step();  // cycle 4
    check("sw c4 mem_req", bus.mem_req, 1);
    check("sw c4 mem_we", bus.mem_we, 1);
    check("sw c4 mem_addr", bus.mem_addr, 32'h0000_0108);
    check("sw c4 mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    check("sw c4 done", bus.done, 1);
    check("sw c4 rd_we", bus.rd_we, 0);
    step();  // cycle 5
    bus.mem_ack = 1'b0;
    check("sw c5 instr_ready", bus.instr_ready, 1);
    check("sw c5 mem_req", bus.mem_req, 0);
    check("sw c5 done", bus.done, 0);

    // Reset during EXEC
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    bus.instr = 32'h002081B3;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();  // cycle 2
    check("rx c2 alu_en", bus.alu_en, 1);
    rst_n = 1'b0;
    #1;
    check("rx alu_en", bus.alu_en, 0);
    check("rx instr_ready", bus.instr_ready, 1);
    check("rx alu_a", bus.alu_a, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("rx after done", bus.done, 0);
      check("rx after rd_we", bus.rd_we, 0);
      check("rx after alu_en", bus.alu_en, 0);
      step();
    end
    check("rx idle", bus.instr_ready, 1);

    // Reset during MEM
    regs[2] = 32'h0000_0100;
    bus.instr = 32'hFFC12203;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    step();
    step();  // cycle 4
    check("rm c4 mem_req", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rm mem_req", bus.mem_req, 0);
    check("rm mem_addr", bus.mem_addr, 0);
    check("rm instr_ready", bus.instr_ready, 1);
    step();
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    for (int c = 0; c < 4; c++) begin
      check("rm after mem_req", bus.mem_req, 0);
      check("rm after rd_we", bus.rd_we, 0);
      check("rm after done", bus.done, 0);
      step();
    end
    bus.mem_ack = 1'b0;
    check("rm idle", bus.instr_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/control sequencer for the non-pipelined RV32I core. It accepts one 32-bit instruction per valid/ready handshake and decodes it into the ALU's opcode/func/operand inputs. It raises a single-cycle ALU enable pulse, captures the ALU result, and completes the instruction: register write-back for R/I-type, or a word memory access for loads/stores. It sits between instruction fetch, the register file, the ALU and data memory.

## Interface
- No parameters (widths fixed: XLEN 32, 32 registers).
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  fetch offers instr
- instr_ready  out  1  high only in IDLE
- instr  in  32  RV32I instruction word
- rs1_addr, rs2_addr  out  5  register file read addresses (instr[19:15], instr[24:20] of latched instr)
- rs1_data, rs2_data  in  32  combinational register file read data
- alu_a, alu_b  out  32  registered ALU operands
- alu_func  out  3  ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110
- alu_opcode  out  7  0110011 R, 0010011 I, 0000001 load, 0100011 store
- alu_en  out  1  ALU trigger; ALU evaluates on its rising edge
- alu_y  in  32  ALU result
- rd_addr  out  5, rd_wdata  out  32, rd_we  out  1  write-back port
- mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  32  data memory request
- mem_ack  in  1, mem_rdata  in  32  memory completion and load data
- done  out  1  one-cycle pulse on completion
- illegal  out  1  one-cycle pulse on unsupported instruction

## Operation
- FSM states: IDLE, DECODE, EXEC, CAPTURE, MEM, WB.
- IDLE: instr_ready=1; on instr_valid latch instr -> DECODE.
- DECODE: register alu_a, alu_b, alu_func and alu_opcode. If the instruction is unsupported, pulse illegal -> IDLE. Otherwise -> EXEC.
- EXEC: alu_en=1 for exactly this cycle; operands held -> CAPTURE.
- CAPTURE: alu_en=0; latch alu_y. R/I -> WB with rd_wdata=alu_y. Load/store -> MEM with mem_addr=alu_y.
- MEM: mem_req=1 and held until mem_ack sampled high. Store: mem_we=1, mem_wdata=rs2_data, -> IDLE with done. Load: rd_wdata=mem_rdata -> WB.
- WB: done=1; rd_we=1 unless rd==0, in which case there is no write.
- Decode rules:
  - R-type: funct3 000/funct7 0000000 ADD; 000/0100000 SUB; 111 AND; 110 OR; 100 XOR; 001 SLL; 101/0000000 SRL.
  - I-type: same funct3 mapping, no SUB. SLLI/SRLI require funct7 0000000.
  - Loads/stores require funct3 010 (LW/SW only).
  - Everything else is illegal: SLT/SLTU, SRA/SRAI, branches, LUI/AUIPC, JAL/JALR, byte/half accesses.
- Operands:
  - alu_a=rs1_data.
  - R-type alu_b=rs2_data, except SLL/SRL, where alu_b={27'b0, rs2_data[4:0]}.
  - I-type alu_b is sign-extended instr[31:20]; SLLI/SRLI use {27'b0, instr[24:20]}.
  - Load alu_b=sext(instr[31:20]); store alu_b=sext({instr[31:25], instr[11:7]}).
  - Loads and stores use alu_func=ADD.
  - RV32I load opcode 0000011 is presented to the ALU as 0000001.

## Timing
- Reset values: all outputs 0 except instr_ready=1 (FSM in IDLE). Asserting rst_n mid-instruction abandons it: no rd_we, mem_req, done or illegal afterwards.
- Operands, alu_func and alu_opcode are stable from the DECODE edge through the end of CAPTURE. They change only in DECODE, so they are always settled one full cycle before alu_en rises.
- R/I latency: handshake at cycle 0; EXEC is cycle 2; WB (rd_we, done) is cycle 4; instr_ready is high again in cycle 5. Throughput is one instruction per 5 cycles.
- Illegal: illegal pulses in cycle 1; instr_ready is high in cycle 2.
- Memory: mem_req rises in cycle 4 and holds while mem_ack=0, with unbounded wait.
  - If mem_ack is already high at cycle 4, a store completes with done in cycle 4.
  - If mem_ack is already high at cycle 4, a load writes back in cycle 5.
  - mem_ack outside MEM is ignored.
- instr_valid while not in IDLE is ignored, since instr_ready=0.
- done and illegal are never high together. alu_en is never high for two consecutive cycles.

## Test plan
- ADD x3,x1,x2 with x1=5, x2=7 -> alu_en pulse in cycle 2; rd_we in cycle 4 with rd_addr=3, rd_wdata=12; done in the same cycle.
- SUB x3,x1,x2 with x1=3, x2=5 -> rd_wdata=0xFFFFFFFE. SLL x4,x1,x2 with x1=1, x2=33 -> alu_b=1, rd_wdata=2.
- SRLI x5,x1,4 with x1=0x80000000 -> alu_b=4, rd_wdata=0x08000000. ADDI x0,x1,1 -> done pulses, rd_we stays 0.
- LW x4,-4(x2) with x2=0x100 -> mem_addr=0xFC, mem_we=0. Hold mem_ack low for 3 cycles, then high with rdata 0xDEADBEEF -> rd 4 written with 0xDEADBEEF. SW x6,8(x2) -> mem_addr=0x108, mem_we=1, mem_wdata=x6, no rd_we.
- SRA (funct7 0100000, funct3 101), BEQ, and LB -> each pulses illegal in cycle 1 with no alu_en, mem_req or rd_we.
- Assert rst_n low during EXEC, and again during MEM -> all outputs return to reset values immediately, no write or done follows, and instr_ready=1 after release.
